bus_arbiter: RTL

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter_pkg.sv | 33 +++
 rtl/bus_arbiter_if.sv | 26 ++
 rtl/bus_arbiter_rr_pick.sv | 28 ++
 rtl/bus_arbiter.sv | 138 +++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the three-unit bus arbiter.
// Holds the FSM state enum, unit ids and small id helpers.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        TURN
    } state_e;

    localparam int         N_UNITS  = 3;
    localparam logic [1:0] SEL_NONE = 2'd0;
    localparam logic [1:0] UNIT_1   = 2'd1;
    localparam logic [1:0] UNIT_2   = 2'd2;
    localparam logic [1:0] UNIT_3   = 2'd3;

    function automatic logic [1:0] next_id(input logic [1:0] id);
        return (id == UNIT_3) ? UNIT_1 : id + 2'd1;
    endfunction

    function automatic logic [N_UNITS-1:0] id_mask(input logic [1:0] id);
        logic [N_UNITS-1:0] m;
        m = '0;
        unique case (id)
            UNIT_1:  m = 3'b001;
            UNIT_2:  m = 3'b010;
            UNIT_3:  m = 3'b100;
            default: m = 3'b000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Request, bus sample and grant signals between the units and the arbiter.
// The arbiter connects through the master modport.
interface bus_arbiter_if #(
    parameter int DATA_W = 2
);
    import bus_pkg::*;

    logic [N_UNITS-1:0] req;
    logic [DATA_W-1:0]  bus;
    logic [1:0]         sel;
    logic [DATA_W-1:0]  rd_data;
    logic               rd_valid;
    logic [1:0]         owner_id;
    logic               timeout;

    modport master (
        input  req, bus,
        output sel, rd_data, rd_valid, owner_id, timeout
    );

    modport slave (
        output req, bus,
        input  sel, rd_data, rd_valid, owner_id, timeout
    );

endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin pick: first requester after last_i in
// order 1->2->3->1; returns SEL_NONE when nothing is requested.
module rr_pick
    import bus_pkg::*;
(
    input  logic [N_UNITS-1:0] req_i,
    input  logic [1:0]         last_i,
    output logic [1:0]         pick_o
);

    logic [1:0] c1, c2, c3;

    assign c1 = next_id(last_i);
    assign c2 = next_id(c1);
    assign c3 = next_id(c2);

    always_comb begin
        pick_o = SEL_NONE;
        if (|(req_i & id_mask(c1))) begin
            pick_o = c1;
        end else if (|(req_i & id_mask(c2))) begin
            pick_o = c2;
        end else if (|(req_i & id_mask(c3))) begin
            pick_o = c3;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Three-unit round-robin bus arbiter with turnaround cycle and bus sampling.
// Define BUS_ARBITER_TIMEOUT_EN to build the hold-limit revocation logic.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int DATA_W   = 2,
    parameter int HOLD_MAX = 15
) (
    input  logic           clk,
    input  logic           rstn,
    bus_arbiter_if.master  bif
);

    if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold
        $error("HOLD_MAX out of range");
    end

    state_e             state_q, state_d;
    logic [1:0]         sel_q, sel_d;
    logic [DATA_W-1:0]  rd_data_q, rd_data_d;
    logic               rd_valid_q, rd_valid_d;
    logic [1:0]         owner_q, owner_d;
    logic [1:0]         last_q, last_d;
    logic [1:0]         pick;
    logic               owner_req;

    rr_pick u_pick (
        .req_i  (bif.req),
        .last_i (last_q),
        .pick_o (pick)
    );

    assign owner_req = |(bif.req & id_mask(sel_q));

`ifdef BUS_ARBITER_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       timeout_q, timeout_d;
    logic       hit_limit;

    // Owner has already shown sel for HOLD_MAX cycles.
    assign hit_limit   = (cnt_q + 8'd1) == 8'(HOLD_MAX);
    assign bif.timeout = timeout_q;
`else
    assign bif.timeout = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        owner_d    = owner_q;
        last_d     = last_q;
`ifdef BUS_ARBITER_TIMEOUT_EN
        cnt_d      = cnt_q;
        timeout_d  = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                sel_d = SEL_NONE;
                if (pick != SEL_NONE) begin
                    state_d = GRANT;
                    sel_d   = pick;
                    last_d  = pick;
`ifdef BUS_ARBITER_TIMEOUT_EN
                    cnt_d   = 8'd0;
`endif
                end
            end
            GRANT: begin
                if (!owner_req) begin
                    state_d = TURN;
                    sel_d   = SEL_NONE;
                end
`ifdef BUS_ARBITER_TIMEOUT_EN
                else if (hit_limit) begin
                    state_d   = TURN;
                    sel_d     = SEL_NONE;
                    last_d    = sel_q;
                    timeout_d = 1'b1;
                end
`endif
                else begin
                    rd_data_d  = bif.bus;
                    owner_d    = sel_q;
                    rd_valid_d = 1'b1;
`ifdef BUS_ARBITER_TIMEOUT_EN
                    cnt_d      = cnt_q + 8'd1;
`endif
                end
            end
            TURN: begin
                sel_d   = SEL_NONE;
                state_d = IDLE;
            end
            default: begin
                sel_d   = SEL_NONE;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= IDLE;
            sel_q      <= SEL_NONE;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            owner_q    <= SEL_NONE;
            last_q     <= UNIT_3;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
        end
    end

`ifdef BUS_ARBITER_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q     <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end
`endif

    assign bif.sel      = sel_q;
    assign bif.rd_data  = rd_data_q;
    assign bif.rd_valid = rd_valid_q;
    assign bif.owner_id = owner_q;

endmodule
